// File: rtl/array_0_7_ctrl_if.sv
// Requester/array bundle for array_0_7_ctrl: two read requesters, one writer,
// flush/init status and the 1R/1W array macro ports.
interface array_0_7_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 6
);
  logic              flush;
  logic              init_done;

  logic              rd0_req_valid;
  logic              rd0_req_ready;
  logic [ADDR_W-1:0] rd0_req_addr;
  logic              rd0_resp_valid;
  logic [DATA_W-1:0] rd0_resp_data;

  logic              rd1_req_valid;
  logic              rd1_req_ready;
  logic [ADDR_W-1:0] rd1_req_addr;
  logic              rd1_resp_valid;
  logic [DATA_W-1:0] rd1_resp_data;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              sram_R0_en;
  logic [ADDR_W-1:0] sram_R0_addr;
  logic [DATA_W-1:0] sram_R0_data;
  logic              sram_W0_en;
  logic [ADDR_W-1:0] sram_W0_addr;
  logic [DATA_W-1:0] sram_W0_data;
  logic              sram_W0_mask;

  // Requesters plus the array macro, seen from outside the controller
  modport master (
    output flush, rd0_req_valid, rd0_req_addr, rd1_req_valid, rd1_req_addr,
           wr_valid, wr_addr, wr_data, sram_R0_data,
    input  init_done, rd0_req_ready, rd0_resp_valid, rd0_resp_data,
           rd1_req_ready, rd1_resp_valid, rd1_resp_data, wr_ready,
           sram_R0_en, sram_R0_addr, sram_W0_en, sram_W0_addr, sram_W0_data,
           sram_W0_mask
  );

  modport slave (
    input  flush, rd0_req_valid, rd0_req_addr, rd1_req_valid, rd1_req_addr,
           wr_valid, wr_addr, wr_data, sram_R0_data,
    output init_done, rd0_req_ready, rd0_resp_valid, rd0_resp_data,
           rd1_req_ready, rd1_resp_valid, rd1_resp_data, wr_ready,
           sram_R0_en, sram_R0_addr, sram_W0_en, sram_W0_addr, sram_W0_data,
           sram_W0_mask
  );
endinterface

// File: rtl/array_0_7_ctrl.sv
// Controller for a 2**ADDR_W x DATA_W 1R/1W metadata array: zero-fill on reset/flush,
// round-robin read port sharing, write pass-through. ARRAY_CTRL_PERF_EN adds perf counters.
module array_0_7_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 6,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  array_0_7_ctrl_if.slave      bus
`ifdef ARRAY_CTRL_PERF_EN
  ,
  output logic [15:0]          perf_rd_conflict,
  output logic [15:0]          perf_wr_cnt,
  output logic [7:0]           perf_init_cnt
`endif
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic              rr_ptr;
  logic              init_done;
  logic              rd0_resp_valid;
  logic              rd1_resp_valid;
  logic              grant0;
  logic              grant1;
  logic              contended;
  logic              in_run;

  assign in_run    = (state == RUN);
  assign contended = in_run && bus.rd0_req_valid && bus.rd1_req_valid;

  // rr_ptr only matters when both requesters collide; otherwise the lone one wins
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (in_run) begin
      if (bus.rd0_req_valid && bus.rd1_req_valid) begin
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = bus.rd0_req_valid;
        grant1 = bus.rd1_req_valid;
      end
    end
  end

  assign bus.rd0_req_ready  = grant0;
  assign bus.rd1_req_ready  = grant1;
  assign bus.sram_R0_en     = grant0 | grant1;
  assign bus.sram_R0_addr   = grant1 ? bus.rd1_req_addr : bus.rd0_req_addr;

  assign bus.wr_ready       = in_run;
  assign bus.sram_W0_en     = in_run ? bus.wr_valid : 1'b1;
  assign bus.sram_W0_addr   = in_run ? bus.wr_addr  : init_ptr;
  assign bus.sram_W0_data   = in_run ? bus.wr_data  : INIT_VAL;
  assign bus.sram_W0_mask   = 1'b1;

  assign bus.init_done      = init_done;
  assign bus.rd0_resp_valid = rd0_resp_valid;
  assign bus.rd1_resp_valid = rd1_resp_valid;
  assign bus.rd0_resp_data  = bus.sram_R0_data;
  assign bus.rd1_resp_data  = bus.sram_R0_data;

  // A flush in RUN still lets that cycle's read/write go through; only the next cycle re-inits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= INIT;
      init_ptr       <= '0;
      rr_ptr         <= 1'b0;
      init_done      <= 1'b0;
      rd0_resp_valid <= 1'b0;
      rd1_resp_valid <= 1'b0;
    end else begin
      rd0_resp_valid <= grant0;
      rd1_resp_valid <= grant1;
      if (contended) begin
        rr_ptr <= ~rr_ptr;
      end
      case (state)
        INIT: begin
          if (bus.flush) begin
            init_ptr <= '0;
          end else if (init_ptr == LAST_ADDR) begin
            state     <= RUN;
            init_ptr  <= '0;
            init_done <= 1'b1;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state     <= INIT;
            init_ptr  <= '0;
            init_done <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef ARRAY_CTRL_PERF_EN
  logic init_complete;
  logic wr_accept;

  assign init_complete = (state == INIT) && !bus.flush && (init_ptr == LAST_ADDR);
  assign wr_accept     = in_run && bus.wr_valid;

  // Saturating counters; flush deliberately leaves them alone
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_rd_conflict <= '0;
      perf_wr_cnt      <= '0;
      perf_init_cnt    <= '0;
    end else begin
      if (contended && (perf_rd_conflict != '1)) begin
        perf_rd_conflict <= perf_rd_conflict + 16'd1;
      end
      if (wr_accept && (perf_wr_cnt != '1)) begin
        perf_wr_cnt <= perf_wr_cnt + 16'd1;
      end
      if (init_complete && (perf_init_cnt != '1)) begin
        perf_init_cnt <= perf_init_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_array_0_7_ctrl.sv
// Directed bench for array_0_7_ctrl with a write-first 256x6 array model.
module tb_array_0_7_ctrl;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   cycle_cnt;

  array_0_7_ctrl_if #(.ADDR_W(8), .DATA_W(6)) bus ();

`ifdef ARRAY_CTRL_PERF_EN
  logic [15:0] perf_rd_conflict;
  logic [15:0] perf_wr_cnt;
  logic [7:0]  perf_init_cnt;
`endif

  array_0_7_ctrl #(.ADDR_W(8), .DATA_W(6), .INIT_VAL(6'd0)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus)
`ifdef ARRAY_CTRL_PERF_EN
    ,
    .perf_rd_conflict (perf_rd_conflict),
    .perf_wr_cnt      (perf_wr_cnt),
    .perf_init_cnt    (perf_init_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Array macro model: write-first when read and write hit the same entry
  logic [5:0] mem [256];
  logic [5:0] rdata;
  always @(posedge clock) begin
    if (bus.sram_W0_en) mem[bus.sram_W0_addr] <= bus.sram_W0_data;
    if (bus.sram_R0_en)
      rdata <= (bus.sram_W0_en && bus.sram_W0_addr == bus.sram_R0_addr) ? bus.sram_W0_data
                                                                          : mem[bus.sram_R0_addr];
  end
  assign bus.sram_R0_data = rdata;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd0v, input logic [7:0] rd0a,
                               input logic rd1v, input logic [7:0] rd1a,
                               input logic wrv, input logic [7:0] wra, input logic [5:0] wrd,
                               input logic fl);
    bus.rd0_req_valid = rd0v;
    bus.rd0_req_addr  = rd0a;
    bus.rd1_req_valid = rd1v;
    bus.rd1_req_addr  = rd1a;
    bus.wr_valid      = wrv;
    bus.wr_addr       = wra;
    bus.wr_data       = wrd;
    bus.flush         = fl;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic waitInitDone(input string tag);
    cycle_cnt = 0;
    while (!bus.init_done && cycle_cnt < 400) begin
      cycle_cnt++;
      nextCycle();
    end
    checkOutput(tag, cycle_cnt, 256);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'h00, 6'h00, 0);
    nextCycle();
    nextCycle();
    checkOutput("reset_init_done", bus.init_done, 0);
    checkOutput("reset_resp_valid", {bus.rd0_resp_valid, bus.rd1_resp_valid}, 0);

    // 1: init sweep, {W0_en, W0_addr, W0_data, init_done} per cycle
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      checkOutput("init_sweep", {bus.sram_W0_en, bus.sram_W0_addr, bus.sram_W0_data, bus.init_done},
                  {1'b1, 8'(i), 6'h00, 1'b0});
      nextCycle();
    end
    checkOutput("init_done_rise", bus.init_done, 1);
    checkOutput("run_idle_w0_en", bus.sram_W0_en, 0);

    // 2: write then read through rd0
    applyStimulus(0, 8'h00, 0, 8'h00, 1, 8'h3C, 6'h2A, 0);
    #1;
    checkOutput("wr_pass", {bus.wr_ready, bus.sram_W0_en, bus.sram_W0_addr, bus.sram_W0_data},
                {1'b1, 1'b1, 8'h3C, 6'h2A});
    nextCycle();
    applyStimulus(1, 8'h3C, 0, 8'h00, 0, 8'h00, 6'h00, 0);
    #1;
    checkOutput("rd0_grant", {bus.rd0_req_ready, bus.rd1_req_ready, bus.sram_R0_en, bus.sram_R0_addr},
                {1'b1, 1'b0, 1'b1, 8'h3C});
    nextCycle();
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'h00, 6'h00, 0);
    checkOutput("rd0_resp", {bus.rd0_resp_valid, bus.rd1_resp_valid, bus.rd0_resp_data},
                {1'b1, 1'b0, 6'h2A});
    nextCycle();
    checkOutput("rd0_resp_clear", bus.rd0_resp_valid, 0);

    // 3: contended reads alternate starting with rd0
    applyStimulus(1, 8'h01, 1, 8'h02, 0, 8'h00, 6'h00, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("rr_grant", {bus.rd0_req_ready, bus.rd1_req_ready, bus.sram_R0_addr},
                  {(k % 2 == 0), (k % 2 == 1), (k % 2 == 0) ? 8'h01 : 8'h02});
      nextCycle();
      checkOutput("rr_resp", {bus.rd0_resp_valid, bus.rd1_resp_valid}, {(k % 2 == 0), (k % 2 == 1)});
    end
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'h00, 6'h00, 0);
    nextCycle();

    // 4: same-cycle write and rd1 read returns the new data
    applyStimulus(0, 8'h00, 1, 8'h10, 1, 8'h10, 6'h15, 0);
    #1;
    checkOutput("rd1_only_grant", {bus.rd0_req_ready, bus.rd1_req_ready, bus.sram_R0_addr},
                {1'b0, 1'b1, 8'h10});
    nextCycle();
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'h00, 6'h00, 0);
    checkOutput("write_first", {bus.rd0_resp_valid, bus.rd1_resp_valid, bus.rd1_resp_data},
                {1'b0, 1'b1, 6'h15});

    // 5: write, then flush together with a read; read still answers, then array is cleared
    applyStimulus(0, 8'h00, 0, 8'h00, 1, 8'h80, 6'h3F, 0);
    nextCycle();
    applyStimulus(1, 8'h80, 0, 8'h00, 0, 8'h00, 6'h00, 1);
    #1;
    checkOutput("flush_rd_grant", bus.rd0_req_ready, 1);
    nextCycle();
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'h00, 6'h00, 0);
    checkOutput("flush_rd_resp", {bus.rd0_resp_valid, bus.rd0_resp_data}, {1'b1, 6'h3F});
    checkOutput("flush_restart", {bus.init_done, bus.sram_W0_en, bus.sram_W0_addr}, {1'b0, 1'b1, 8'h00});
    waitInitDone("flush_init_len");
    applyStimulus(1, 8'h80, 0, 8'h00, 0, 8'h00, 6'h00, 0);
    nextCycle();
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'h00, 6'h00, 0);
    checkOutput("cleared_read", {bus.rd0_resp_valid, bus.rd0_resp_data}, {1'b1, 6'h00});

`ifdef ARRAY_CTRL_PERF_EN
    checkOutput("perf_conflict", perf_rd_conflict, 4);
    checkOutput("perf_wr", perf_wr_cnt, 3);
    checkOutput("perf_init", perf_init_cnt, 2);
`endif

    // 6: reset drops a pending response, then reset again mid-init at 0x40
    reset = 1'b1;
    #1;
    checkOutput("reset_drops_resp", {bus.rd0_resp_valid, bus.rd1_resp_valid, bus.init_done}, 0);
    reset = 1'b0;
    #1;
    checkOutput("reinit_addr0", {bus.sram_W0_en, bus.sram_W0_addr}, {1'b1, 8'h00});
    repeat (64) nextCycle();
    checkOutput("init_at_40", bus.sram_W0_addr, 8'h40);
    applyStimulus(1, 8'h05, 1, 8'h06, 0, 8'h00, 6'h00, 0);
    #1;
    checkOutput("init_blocks_reqs", {bus.rd0_req_ready, bus.rd1_req_ready, bus.sram_R0_en, bus.wr_ready}, 0);
    reset = 1'b1;
    #1;
    checkOutput("midinit_reset", {bus.init_done, bus.sram_W0_addr}, {1'b0, 8'h00});
`ifdef ARRAY_CTRL_PERF_EN
    checkOutput("perf_init_aborted", perf_init_cnt, 0);
`endif
    reset = 1'b0;
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'h00, 6'h00, 0);
    waitInitDone("post_reset_init_len");
`ifdef ARRAY_CTRL_PERF_EN
    checkOutput("perf_init_after", perf_init_cnt, 1);
`endif

    // 7: flush during INIT restarts from entry 0
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'h00, 6'h00, 1);
    nextCycle();
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'h00, 6'h00, 0);
    repeat (5) nextCycle();
    checkOutput("init_at_5", bus.sram_W0_addr, 8'h05);
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'h00, 6'h00, 1);
    nextCycle();
    applyStimulus(0, 8'h00, 0, 8'h00, 0, 8'h00, 6'h00, 0);
    checkOutput("init_flush_restart", {bus.init_done, bus.sram_W0_addr}, {1'b0, 8'h00});
    waitInitDone("restart_init_len");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
